// File: rtl/ram_mmu_tlb.sv
// Paging MMU: translates virtual to physical addresses through a small fully
// associative TLB, walking the page table over a req/ack port on a miss.
module ram_mmu_tlb #(
  parameter int VADDR_W     = 16,
  parameter int PAGE_BITS   = 11,
  parameter int PADDR_W     = 18,
  parameter int PTB_W       = 12,
  parameter int PT_ADDR_W   = 9,
  parameter int TLB_ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [VADDR_W-1:0]   req_addr,
  input  logic                 req_write,
  input  logic [PTB_W-1:0]     ptb,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic [PADDR_W-1:0]   resp_addr,
  output logic                 resp_fault_unassigned,
  output logic                 resp_fault_ro,
  output logic                 pt_req,
  output logic [PT_ADDR_W-1:0] pt_addr,
  input  logic                 pt_ack,
  input  logic [15:0]          pt_entry,
  output logic                 tlb_hit
);

  localparam int VPN_W   = VADDR_W - PAGE_BITS;
  localparam int FRAME_W = PADDR_W - PAGE_BITS;
  localparam int IDX_W   = $clog2(TLB_ENTRIES);
  localparam int SUM_A   = (PTB_W > VPN_W) ? PTB_W : VPN_W;
  localparam int SUM_W   = ((SUM_A > PT_ADDR_W) ? SUM_A : PT_ADDR_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [VADDR_W-1:0]     vaddr_q, vaddr_d;
  logic                   write_q, write_d;
  logic [PTB_W-1:0]       ptb_q;
  logic [PT_ADDR_W-1:0]   pt_addr_q, pt_addr_d;
  logic                   no_fill_q, no_fill_d;
  logic [IDX_W-1:0]       victim_q, victim_d;
  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_W-1:0]       tag_q   [TLB_ENTRIES];
  logic [VPN_W-1:0]       tag_d   [TLB_ENTRIES];
  logic [FRAME_W-1:0]     frame_q [TLB_ENTRIES];
  logic [FRAME_W-1:0]     frame_d [TLB_ENTRIES];
  logic                   ro_q    [TLB_ENTRIES];
  logic                   ro_d    [TLB_ENTRIES];
  logic [PADDR_W-1:0]     resp_addr_q, resp_addr_d;
  logic                   fault_u_q, fault_u_d;
  logic                   fault_ro_q, fault_ro_d;
  logic                   hit_q, hit_d;

  logic [VPN_W-1:0]       lookup_vpn;
  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;
  logic                   tlb_clear;
  logic                   unused_entry_bits;

  assign unused_entry_bits = ^pt_entry;
  assign lookup_vpn = req_addr[VADDR_W-1:PAGE_BITS];
  assign tlb_clear  = flush | (ptb != ptb_q);

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips the assignment infers a latch.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_vpn) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    write_d     = write_q;
    pt_addr_d   = pt_addr_q;
    no_fill_d   = no_fill_q;
    victim_d    = victim_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    frame_d     = frame_q;
    ro_d        = ro_q;
    resp_addr_d = resp_addr_q;
    fault_u_d   = fault_u_q;
    fault_ro_d  = fault_ro_q;
    hit_d       = hit_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          vaddr_d = req_addr;
          write_d = req_write;
          if (hit_any) begin
            resp_addr_d = {frame_q[hit_idx], req_addr[PAGE_BITS-1:0]};
            fault_u_d   = 1'b0;
            fault_ro_d  = ro_q[hit_idx] & req_write;
            hit_d       = 1'b1;
            state_d     = S_RESP;
          end else begin
            pt_addr_d = PT_ADDR_W'(SUM_W'(lookup_vpn) + SUM_W'(ptb));
            no_fill_d = 1'b0;
            state_d   = S_WALK;
          end
        end
      end
      S_WALK: begin
        // An invalidation seen mid-walk makes the fetched entry stale for caching.
        if (tlb_clear) no_fill_d = 1'b1;
        if (pt_ack) begin
          resp_addr_d = {pt_entry[FRAME_W-1:0], vaddr_q[PAGE_BITS-1:0]};
          fault_u_d   = ~pt_entry[15];
          fault_ro_d  = pt_entry[15] & pt_entry[14] & write_q;
          hit_d       = 1'b0;
          state_d     = S_RESP;
          if (pt_entry[15] && !no_fill_q && !tlb_clear) begin
            tag_d[victim_q]   = vaddr_q[VADDR_W-1:PAGE_BITS];
            frame_d[victim_q] = pt_entry[FRAME_W-1:0];
            ro_d[victim_q]    = pt_entry[14];
            valid_d[victim_q] = 1'b1;
            victim_d          = victim_q + 1'b1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tlb_clear) valid_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vaddr_q     <= '0;
      write_q     <= 1'b0;
      ptb_q       <= '0;
      pt_addr_q   <= '0;
      no_fill_q   <= 1'b0;
      victim_q    <= '0;
      valid_q     <= '0;
      resp_addr_q <= '0;
      fault_u_q   <= 1'b0;
      fault_ro_q  <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      write_q     <= write_d;
      ptb_q       <= ptb;
      pt_addr_q   <= pt_addr_d;
      no_fill_q   <= no_fill_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      resp_addr_q <= resp_addr_d;
      fault_u_q   <= fault_u_d;
      fault_ro_q  <= fault_ro_d;
      hit_q       <= hit_d;
    end
  end

  // NOTE: the entry payload is not reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    frame_q <= frame_d;
    ro_q    <= ro_d;
  end

  assign req_ready             = (state_q == S_IDLE);
  assign resp_valid            = (state_q == S_RESP);
  assign pt_req                = (state_q == S_WALK);
  assign pt_addr               = pt_addr_q;
  assign resp_addr             = resp_addr_q;
  assign resp_fault_unassigned = resp_valid & fault_u_q;
  assign resp_fault_ro         = resp_valid & fault_ro_q;
  assign tlb_hit               = resp_valid & hit_q;

endmodule

// File: tb/tb_ram_mmu_tlb.sv
// Directed bench for ram_mmu_tlb: hits, misses, faults, round-robin eviction,
// flush during a walk, reset mid-walk and page-table address wrap.
module tb_ram_mmu_tlb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [11:0] ptb = 12'h010;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [17:0] resp_addr;
  logic        resp_fault_unassigned;
  logic        resp_fault_ro;
  logic        pt_req;
  logic [8:0]  pt_addr;
  logic        pt_ack = 1'b0;
  logic [15:0] pt_entry = '0;
  logic        tlb_hit;

  ram_mmu_tlb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .ptb(ptb), .flush(flush),
    .resp_valid(resp_valid), .resp_addr(resp_addr),
    .resp_fault_unassigned(resp_fault_unassigned), .resp_fault_ro(resp_fault_ro),
    .pt_req(pt_req), .pt_addr(pt_addr), .pt_ack(pt_ack), .pt_entry(pt_entry),
    .tlb_hit(tlb_hit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [17:0] r_addr;
  logic        r_fu, r_fro, r_hit, r_walk;
  logic [8:0]  r_ptaddr;
  int          r_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pa(input logic [6:0] frame, input logic [15:0] va);
    return {frame, va[10:0]};
  endfunction

  // One translation; acks the walk immediately, or one cycle after a flush pulse.
  task automatic do_req(input logic [15:0] addr, input logic wr,
                        input logic [15:0] entry, input logic flush_mid);
    bit done = 0;
    bit flushed = 0;
    r_walk = 0; r_ptaddr = '0; r_lat = 0;
    r_addr = '0; r_fu = 0; r_fro = 0; r_hit = 0;
    @(negedge clk);
    check("req_ready", {31'd0, req_ready}, 1);
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    for (int i = 1; i <= 20 && !done; i++) begin
      flush = 1'b0; pt_ack = 1'b0;
      if (resp_valid) begin
        done = 1; r_lat = i; r_addr = resp_addr;
        r_fu = resp_fault_unassigned; r_fro = resp_fault_ro; r_hit = tlb_hit;
      end else begin
        if (pt_req) begin
          r_walk = 1; r_ptaddr = pt_addr;
          if (flush_mid && !flushed) begin
            flush = 1'b1; flushed = 1;
          end else begin
            pt_ack = 1'b1; pt_entry = entry;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) check("resp_timeout", 0, 1);
    else begin
      @(negedge clk);
      check("resp_one_cycle", {31'd0, resp_valid}, 0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_pt_req", {31'd0, pt_req}, 0);
    check("rst_tlb_hit", {31'd0, tlb_hit}, 0);
    check("rst_resp_addr", {14'd0, resp_addr}, 0);
    check("rst_pt_addr", {23'd0, pt_addr}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: first miss
    do_req(16'h0805, 0, 16'h8023, 0);
    check("t1_walk", {31'd0, r_walk}, 1);
    check("t1_pt_addr", {23'd0, r_ptaddr}, 32'h011);
    check("t1_addr", {14'd0, r_addr}, 32'h11805);
    check("t1_fu", {31'd0, r_fu}, 0);
    check("t1_fro", {31'd0, r_fro}, 0);
    check("t1_hit", {31'd0, r_hit}, 0);
    check("t1_lat", r_lat, 2);

    // 2: hit on the same page
    do_req(16'h0FFF, 0, 16'hDEAD, 0);
    check("t2_walk", {31'd0, r_walk}, 0);
    check("t2_hit", {31'd0, r_hit}, 1);
    check("t2_lat", r_lat, 1);
    check("t2_addr", {14'd0, r_addr}, 32'h11FFF);

    // 3: store to read-only page, then read and store hits
    do_req(16'h1000, 1, 16'hC005, 0);
    check("t3_pt_addr", {23'd0, r_ptaddr}, 32'h012);
    check("t3_fro", {31'd0, r_fro}, 1);
    check("t3_addr", {14'd0, r_addr}, 32'h02800);
    do_req(16'h1000, 0, 16'h0000, 0);
    check("t3_rd_hit", {31'd0, r_hit}, 1);
    check("t3_rd_fro", {31'd0, r_fro}, 0);
    check("t3_rd_fu", {31'd0, r_fu}, 0);
    do_req(16'h1000, 1, 16'h0000, 0);
    check("t3_wr_hit", {31'd0, r_hit}, 1);
    check("t3_wr_fro", {31'd0, r_fro}, 1);

    // 4: unassigned page is never cached
    do_req(16'h1800, 0, 16'h0000, 0);
    check("t4_fu", {31'd0, r_fu}, 1);
    check("t4_fro", {31'd0, r_fro}, 0);
    do_req(16'h1800, 0, 16'h0000, 0);
    check("t4_rewalk", {31'd0, r_walk}, 1);
    check("t4_fu2", {31'd0, r_fu}, 1);

    // 5: round-robin eviction over five pages
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int v = 4; v <= 8; v++) begin
      do_req(16'((v << 11) | 16'h123), 0, 16'(16'h8040 | v), 0);
      check("t5_fill_walk", {31'd0, r_walk}, 1);
      check("t5_fill_addr", {14'd0, r_addr}, {14'd0, pa(7'(8'h40 | v), 16'h0123)});
    end
    for (int v = 5; v <= 8; v++) begin
      do_req(16'((v << 11) | 16'h456), 0, 16'h0000, 0);
      check("t5_resident_hit", {31'd0, r_hit}, 1);
      check("t5_resident_addr", {14'd0, r_addr}, {14'd0, pa(7'(8'h40 | v), 16'h0456)});
    end
    do_req(16'h2000, 0, 16'h8044, 0);
    check("t5_evicted_walk", {31'd0, r_walk}, 1);

    do_req(16'h4923, 0, 16'h8049, 1);
    check("t5_flush_walk", {31'd0, r_walk}, 1);
    check("t5_flush_addr", {14'd0, r_addr}, {14'd0, pa(7'h49, 16'h4923)});
    check("t5_flush_fu", {31'd0, r_fu}, 0);
    for (int v = 5; v <= 9; v++) begin
      do_req(16'((v << 11) | 16'h001), 0, 16'(16'h8040 | v), 0);
      check("t5_post_flush_walk", {31'd0, r_walk}, 1);
    end
    do_req(16'h4800, 0, 16'h0000, 0);
    check("t5_refill_hit", {31'd0, r_hit}, 1);

    // 6: reset during a walk
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h2800; req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t6_walking", {31'd0, pt_req}, 1);
    rst_n = 1'b0;
    #1;
    check("t6_pt_req", {31'd0, pt_req}, 0);
    check("t6_resp_valid", {31'd0, resp_valid}, 0);
    check("t6_req_ready", {31'd0, req_ready}, 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_req(16'h4800, 0, 16'h8049, 0);
    check("t6_miss_after_rst", {31'd0, r_walk}, 1);
    check("t6_hit_after_rst", {31'd0, r_hit}, 0);

    // Page-table address wraps past PT_ADDR_W
    ptb = 12'h1FF;
    repeat (2) @(negedge clk);
    do_req(16'h0805, 0, 16'h8023, 0);
    check("wrap_pt_addr", {23'd0, r_ptaddr}, 32'h000);
    check("wrap_addr", {14'd0, r_addr}, 32'h11805);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
